spike_synapse_mac: RTL and testbench

- Presynaptic integration stage that drives the in_valid/in_mac_sum interface of a neuron body.
- Latches one timestep's binary input spike vector and accumulates the stored synaptic weight of every spiking input, one input per cycle.
- Emits a single-cycle valid pulse carrying the weighted sum, saturated to the neuron's MAX_VAL.
- Holds a register-file weight table writable by a host/loader port.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/spike_synapse_mac_if.sv | 28 ++
 rtl/synapse_weight_rf.sv | 37 +++
 rtl/spike_synapse_mac.sv | 118 +++++++++++
 tb/tb_spike_synapse_mac.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: FSM encoding, default
// saturation ceiling and the output clamp used by the synapse integrator.
package snn_pkg;

    localparam int SNN_MAX_VAL = 100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } syn_state_e;

    // Clamp a sign-extended sum into [0, max_val].
    // An unsigned sum arrives zero-extended, so only the upper bound can apply to it.
    function automatic logic [31:0] sat_clamp(input logic signed [31:0] v, input int max_val);
        logic [31:0] r;
        if (v < 0) begin
            r = '0;
        end else if (v >= max_val) begin
            r = 32'(max_val);
        end else begin
            r = $unsigned(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_synapse_mac_if.sv
// Spike-vector start/result handshake and weight loader port of the synapse integrator.
interface spike_synapse_mac_if #(
    parameter int NUM_IN       = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8
);
    localparam int ADDR_W = $clog2(NUM_IN);

    logic                    in_start;
    logic [NUM_IN-1:0]       in_spikes;
    logic                    wt_we;
    logic [ADDR_W-1:0]       wt_addr;
    logic [WEIGHT_WIDTH-1:0] wt_wdata;
    logic                    busy;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_mac_sum;

    modport master (
        output in_start, in_spikes, wt_we, wt_addr, wt_wdata,
        input  busy, out_valid, out_mac_sum
    );

    modport slave (
        input  in_start, in_spikes, wt_we, wt_addr, wt_wdata,
        output busy, out_valid, out_mac_sum
    );

endinterface

// File: rtl/synapse_weight_rf.sv
// Synaptic weight table: one write port, one asynchronous read port, cleared on reset.
// A read of the address being written this cycle returns the old weight.
module synapse_weight_rf #(
    parameter int NUM_IN       = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_W       = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [WEIGHT_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [WEIGHT_WIDTH-1:0] rdata
);

    logic [WEIGHT_WIDTH-1:0] w_q [NUM_IN];
    logic [WEIGHT_WIDTH-1:0] w_d [NUM_IN];

    always_comb begin
        w_d = w_q;
        if (we) begin
            w_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '{default: '0};
        end else begin
            w_q <= w_d;
        end
    end

    assign rdata = w_q[raddr];

endmodule

// File: rtl/spike_synapse_mac.sv
// Presynaptic integrator: sums the weights of all spiking inputs, one input per cycle,
// and emits a saturated result pulse. Define SYNAPSE_INHIBIT_EN for signed (inhibitory) weights.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for in_start; weights may still be written
// S_ACCUM | walking idx 0..NUM_IN-1, adding w[idx] where spike[idx]=1
// S_OUT   | out_valid pulse; clamped sum presented on out_mac_sum
module spike_synapse_mac
    import snn_pkg::*;
#(
    parameter int NUM_IN       = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAX_VAL      = SNN_MAX_VAL
) (
    input  logic               clk,
    input  logic               rst,
    spike_synapse_mac_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_IN);
    localparam int ACC_W  = WEIGHT_WIDTH + ADDR_W + 1;

    syn_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [NUM_IN-1:0]       spikes_q, spikes_d;
    logic [DATA_WIDTH-1:0]   out_sum_q, out_sum_d;

    logic [WEIGHT_WIDTH-1:0] w_rdata;
    logic [ACC_W-1:0]        w_ext;
    logic [ACC_W-1:0]        acc_sum;
    logic signed [31:0]      acc_ext;

    synapse_weight_rf #(
        .NUM_IN       (NUM_IN),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .ADDR_W       (ADDR_W)
    ) u_weight_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.wt_we),
        .waddr (bus.wt_addr),
        .wdata (bus.wt_wdata),
        .raddr (idx_q),
        .rdata (w_rdata)
    );

    always_comb begin
`ifdef SYNAPSE_INHIBIT_EN
        w_ext   = {{(ACC_W-WEIGHT_WIDTH){w_rdata[WEIGHT_WIDTH-1]}}, w_rdata};
`else
        w_ext   = {{(ACC_W-WEIGHT_WIDTH){1'b0}}, w_rdata};
`endif
        acc_sum = acc_q + (spikes_q[idx_q] ? w_ext : '0);
`ifdef SYNAPSE_INHIBIT_EN
        acc_ext = {{(32-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
`else
        acc_ext = {{(32-ACC_W){1'b0}}, acc_sum};
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        spikes_d  = spikes_q;
        out_sum_d = out_sum_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    spikes_d = bus.in_spikes;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_sum;
                idx_d = idx_q + ADDR_W'(1);
                // The result is captured on the last accumulate edge so it is
                // already on out_mac_sum during the S_OUT pulse.
                if (idx_q == ADDR_W'(NUM_IN - 1)) begin
                    out_sum_d = DATA_WIDTH'(sat_clamp(acc_ext, MAX_VAL));
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            spikes_q  <= '0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            spikes_q  <= spikes_d;
            out_sum_q <= out_sum_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.out_mac_sum = out_sum_q;

endmodule

// File: tb/tb_spike_synapse_mac.sv
// Directed bench for spike_synapse_mac: table of weight/spike vectors plus
// hand-written sequences for held start, mid-run reset and mid-run weight write.
module tb_spike_synapse_mac;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    spike_synapse_mac_if #(.NUM_IN(16), .DATA_WIDTH(8), .WEIGHT_WIDTH(8)) bus ();

    spike_synapse_mac #(
        .NUM_IN       (16),
        .DATA_WIDTH   (8),
        .WEIGHT_WIDTH (8),
        .MAX_VAL      (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          w_is_idx;
        logic [7:0]  w_const;
        logic [15:0] spikes;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [3:0] a, input logic [7:0] d);
        bus.wt_we    = 1'b1;
        bus.wt_addr  = a;
        bus.wt_wdata = d;
        step();
        bus.wt_we    = 1'b0;
    endtask

    task automatic load_weights(input bit is_idx, input logic [7:0] c);
        for (int i = 0; i < 16; i++) begin
            write_w(4'(i), is_idx ? 8'(i) : c);
        end
    endtask

    // Ends one sample after the accepting edge (sample index 1).
    task automatic start_run(input logic [15:0] sp);
        bus.in_start  = 1'b1;
        bus.in_spikes = sp;
        step();
        bus.in_start  = 1'b0;
    endtask

    task automatic wait_result(input int s0, output int lat, output int sum, output bit busy_ok);
        lat     = 0;
        sum     = -1;
        busy_ok = 1'b1;
        for (int s = s0; s <= 60; s++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.out_valid === 1'b1) begin
                lat = s;
                sum = int'(bus.out_mac_sum);
                break;
            end
            step();
        end
    endtask

    task automatic run_vec(input logic [15:0] sp, input int exp, input string nm);
        int lat;
        int sum;
        bit busy_ok;
        start_run(sp);
        wait_result(1, lat, sum, busy_ok);
        check({nm, "_lat"}, lat, 17);
        check({nm, "_sum"}, sum, exp);
        check({nm, "_busy"}, int'(busy_ok), 1);
        step();
        check({nm, "_idle"}, int'({bus.busy, bus.out_valid}), 0);
    endtask

    initial begin
        int pulses;
        int first_s;
        int last_s;
        int lat;
        int sum;
        bit busy_ok;

        vecs[0]  = '{"part",   1'b1, 8'd0,   16'h000F, 8'd6};
        vecs[1]  = '{"sat",    1'b0, 8'd10,  16'hFFFF, 8'd100};
        vecs[2]  = '{"six",    1'b0, 8'd6,   16'h00FF, 8'd48};
        vecs[3]  = '{"empty",  1'b1, 8'd0,   16'h0000, 8'd0};
        vecs[4]  = '{"ends",   1'b1, 8'd0,   16'h8001, 8'd15};
        vecs[5]  = '{"odd",    1'b1, 8'd0,   16'hAAAA, 8'd64};
        vecs[6]  = '{"even",   1'b1, 8'd0,   16'h5555, 8'd56};
        vecs[7]  = '{"allidx", 1'b1, 8'd0,   16'hFFFF, 8'd100};
        vecs[8]  = '{"below",  1'b0, 8'd99,  16'h0001, 8'd99};
        vecs[9]  = '{"equal",  1'b0, 8'd100, 16'h0001, 8'd100};
        vecs[10] = '{"above",  1'b0, 8'd101, 16'h0001, 8'd100};
        vecs[11] = '{"big",    1'b0, 8'd127, 16'hFFFF, 8'd100};

        rst           = 1'b1;
        bus.in_start  = 1'b0;
        bus.in_spikes = '0;
        bus.wt_we     = 1'b0;
        bus.wt_addr   = '0;
        bus.wt_wdata  = '0;
        step();
        step();
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_sum",   int'(bus.out_mac_sum), 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 12; v++) begin
            load_weights(vecs[v].w_is_idx, vecs[v].w_const);
            run_vec(vecs[v].spikes, int'(vecs[v].exp), vecs[v].nm);
        end

        // in_start held high across three full periods: one accept every 18 cycles.
        load_weights(1'b1, 8'd0);
        bus.in_start  = 1'b1;
        bus.in_spikes = 16'h000F;
        pulses  = 0;
        first_s = 0;
        last_s  = 0;
        for (int s = 1; s <= 54; s++) begin
            step();
            if (bus.out_valid === 1'b1) begin
                pulses++;
                if (first_s == 0) first_s = s;
                last_s = s;
                check("held_sum", int'(bus.out_mac_sum), 6);
            end
        end
        bus.in_start = 1'b0;
        check("held_pulses", pulses, 3);
        check("held_first",  first_s, 17);
        check("held_last",   last_s, 53);
        step();

        // Reset partway through accumulation abandons the run and clears weights.
        load_weights(1'b0, 8'd10);
        start_run(16'hFFFF);
        for (int s = 2; s <= 5; s++) step();
        rst = 1'b1;
        #1;
        check("mrst_busy",  int'(bus.busy), 0);
        check("mrst_valid", int'(bus.out_valid), 0);
        check("mrst_sum",   int'(bus.out_mac_sum), 0);
        step();
        rst    = 1'b0;
        pulses = 0;
        for (int s = 0; s < 30; s++) begin
            step();
            if (bus.out_valid === 1'b1) pulses++;
        end
        check("mrst_nopulse", pulses, 0);
        run_vec(16'hFFFF, 0, "wclr");

        // Weight 15 rewritten while idx=3 is being processed; the new value is used.
        load_weights(1'b1, 8'd0);
        start_run(16'h8001);
        for (int s = 2; s <= 4; s++) step();
        bus.wt_we    = 1'b1;
        bus.wt_addr  = 4'd15;
        bus.wt_wdata = 8'd50;
        step();
        bus.wt_we    = 1'b0;
        wait_result(5, lat, sum, busy_ok);
        check("mwr_lat",  lat, 17);
        check("mwr_sum",  sum, 50);
        check("mwr_busy", int'(busy_ok), 1);
        step();

        // Weight 0xEC is -20 when inhibitory synapses are enabled, 236 otherwise.
        write_w(4'd0, 8'hEC);
        write_w(4'd1, 8'd5);
`ifdef SYNAPSE_INHIBIT_EN
        run_vec(16'h0003, 0, "inh_neg");
        write_w(4'd1, 8'd30);
        run_vec(16'h0003, 10, "inh_pos");
`else
        run_vec(16'h0003, 100, "inh_neg");
        write_w(4'd1, 8'd30);
        run_vec(16'h0003, 100, "inh_pos");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
